// File: rtl/dsound_pkg.sv
// rtl/dsound_pkg.sv - shared types and constants for the Direct Sound FIFO producer side
package dsound_pkg;

  localparam int DSOUND_FIFO_DEPTH   = 8;
  localparam int DSOUND_REFILL_LEVEL = 4;

  typedef logic [3:0]  fifo_size_t;
  typedef logic [31:0] fifo_word_t;

  // Byte lanes of a sample word: L half = lanes 0..1, H half = lanes 2..3
  localparam int LANE_L_LO = 0;
  localparam int LANE_L_HI = 1;
  localparam int LANE_H_LO = 2;
  localparam int LANE_H_HI = 3;

  function automatic logic needs_refill(input fifo_size_t size);
    return size <= fifo_size_t'(DSOUND_REFILL_LEVEL);
  endfunction

endpackage

// File: rtl/dsound_fifo_stage.sv
// rtl/dsound_fifo_stage.sv - byte-lane staging register that assembles bus writes into sample words
module dsound_fifo_stage
  import dsound_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       wr_en,
  input  logic [3:0] wr_be,
  input  fifo_word_t wr_data,
  output logic       commit,
  output fifo_word_t word
);

  fifo_word_t staging;
  logic [3:0] lane_vld;
  logic [3:0] be_eff;

  assign be_eff = wr_en ? wr_be : 4'h0;
  // Writing the top lane closes the word, whatever lanes arrived before it
  assign commit = be_eff[LANE_H_HI];

  always_comb begin
    word = '0;
    for (int i = 0; i < 4; i++) begin
      if (be_eff[i])
        word[8*i +: 8] = wr_data[8*i +: 8];
      else if (lane_vld[i])
        word[8*i +: 8] = staging[8*i +: 8];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      staging  <= '0;
      lane_vld <= '0;
    end else if (clr || commit) begin
      staging  <= '0;
      lane_vld <= '0;
    end else if (wr_en) begin
      staging  <= word;
      lane_vld <= lane_vld | wr_be;
    end
  end

endmodule

// File: rtl/direct_sound_fifo.sv
// rtl/direct_sound_fifo.sv - Direct Sound channel word FIFO with lane-merging producer side
// Optional sticky error flags: DSOUND_FIFO_STICKY_EN
module direct_sound_fifo
  import dsound_pkg::*;
#(
  parameter int DEPTH  = DSOUND_FIFO_DEPTH,
  parameter int DATA_W = 32
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        wr_en,
  input  logic [3:0]  wr_be,
  input  logic [31:0] wr_data,
  input  logic        FIFO_re,
  input  logic        FIFO_clr,
  output logic [31:0] FIFO_value,
  output logic [3:0]  FIFO_size,
  output logic        full,
  output logic        overflow,
  output logic        underflow
`ifdef DSOUND_FIFO_STICKY_EN
  ,
  input  logic        status_clr,
  output logic        ovf_sticky,
  output logic        udf_sticky
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count, count_nxt;

  logic       push, push_ok, pop_ok;
  logic       ovf_nxt, udf_nxt;
  fifo_word_t push_word;

  dsound_fifo_stage u_stage (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (FIFO_clr),
    .wr_en   (wr_en),
    .wr_be   (wr_be),
    .wr_data (wr_data),
    .commit  (push),
    .word    (push_word)
  );

  // A same-cycle pop frees the slot, so a full FIFO still accepts the push
  assign pop_ok  = FIFO_re && (count != '0);
  assign push_ok = push && ((count != CW'(DEPTH)) || pop_ok);
  assign ovf_nxt = push && !push_ok;
  assign udf_nxt = FIFO_re && (count == '0);

  always_comb begin
    count_nxt = count;
    case ({push_ok, pop_ok})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (FIFO_clr) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      count     <= count_nxt;
      overflow  <= ovf_nxt;
      underflow <= udf_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (!FIFO_clr && push_ok)
      mem[wr_ptr] <= push_word;
  end

  assign FIFO_value = (count != '0) ? mem[rd_ptr] : '0;
  assign FIFO_size  = fifo_size_t'(count);
  assign full       = (count == CW'(DEPTH));

`ifdef DSOUND_FIFO_STICKY_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ovf_sticky <= 1'b0;
      udf_sticky <= 1'b0;
    end else if (FIFO_clr) begin
      ovf_sticky <= 1'b0;
      udf_sticky <= 1'b0;
    end else begin
      if (ovf_nxt)         ovf_sticky <= 1'b1;
      else if (status_clr) ovf_sticky <= 1'b0;
      if (udf_nxt)         udf_sticky <= 1'b1;
      else if (status_clr) udf_sticky <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_direct_sound_fifo.sv
// tb/tb_direct_sound_fifo.sv - directed self-checking bench for direct_sound_fifo
module tb_direct_sound_fifo;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_be = 4'h0;
  logic [31:0] wr_data = 32'h0;
  logic        FIFO_re = 1'b0;
  logic        FIFO_clr = 1'b0;
  logic [31:0] FIFO_value;
  logic [3:0]  FIFO_size;
  logic        full, overflow, underflow;
`ifdef DSOUND_FIFO_STICKY_EN
  logic        status_clr = 1'b0;
  logic        ovf_sticky, udf_sticky;
`endif

  int n_checks = 0;
  int n_errors = 0;

  direct_sound_fifo dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .wr_en      (wr_en),
    .wr_be      (wr_be),
    .wr_data    (wr_data),
    .FIFO_re    (FIFO_re),
    .FIFO_clr   (FIFO_clr),
    .FIFO_value (FIFO_value),
    .FIFO_size  (FIFO_size),
    .full       (full),
    .overflow   (overflow),
    .underflow  (underflow)
`ifdef DSOUND_FIFO_STICKY_EN
    ,
    .status_clr (status_clr),
    .ovf_sticky (ovf_sticky),
    .udf_sticky (udf_sticky)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [3:0] be, input logic [31:0] d);
    wr_en = 1'b1; wr_be = be; wr_data = d;
    cyc();
    wr_en = 1'b0; wr_be = 4'h0; wr_data = 32'h0;
  endtask

  task automatic pop();
    FIFO_re = 1'b1;
    cyc();
    FIFO_re = 1'b0;
  endtask

  initial begin
    #2;
    check("rst_size", 32'(FIFO_size), 32'd0);
    check("rst_value", FIFO_value, 32'h0);
    check("rst_flags", {29'h0, full, overflow, underflow}, 32'h0);
    cyc();
    reset_n = 1'b1;
    cyc();

    // Single word write
    wr(4'hF, 32'h44332211);
    check("word_size", 32'(FIFO_size), 32'd1);
    check("word_value", FIFO_value, 32'h44332211);
    pop();
    check("word_pop_size", 32'(FIFO_size), 32'd0);

    // Halfword L then H
    wr(4'h3, 32'h0000BBAA);
    check("half_l_size", 32'(FIFO_size), 32'd0);
    wr(4'hC, 32'hDDCC0000);
    check("half_h_size", 32'(FIFO_size), 32'd1);
    check("half_value", FIFO_value, 32'hDDCCBBAA);
    pop();

    // Fill to overflow
    for (int i = 1; i <= 9; i++) begin
      wr(4'hF, 32'(i));
      if (i == 8) check("fill8_ovf", 32'(overflow), 32'd0);
    end
    check("fill_size", 32'(FIFO_size), 32'd8);
    check("fill_full", 32'(full), 32'd1);
    check("fill_ovf", 32'(overflow), 32'd1);
    cyc();
    check("ovf_pulse_end", 32'(overflow), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("drain_%0d", i), FIFO_value, 32'(i));
      pop();
    end
    check("drain_value", FIFO_value, 32'h0);
    check("drain_size", 32'(FIFO_size), 32'd0);
    pop();
    check("empty_udf", 32'(underflow), 32'd1);
    cyc();
    check("udf_pulse_end", 32'(underflow), 32'd0);

    // Push and pop together while full
    for (int i = 1; i <= 8; i++) wr(4'hF, 32'h10 + 32'(i));
    FIFO_re = 1'b1;
    wr(4'hF, 32'hA5A5A5A5);
    FIFO_re = 1'b0;
    check("fullpp_size", 32'(FIFO_size), 32'd8);
    check("fullpp_ovf", 32'(overflow), 32'd0);
    check("fullpp_head", FIFO_value, 32'h12);
    for (int i = 0; i < 7; i++) pop();
    check("fullpp_new", FIFO_value, 32'hA5A5A5A5);
    pop();
    check("fullpp_empty", 32'(FIFO_size), 32'd0);

    // Push and pop together while empty
    FIFO_re = 1'b1;
    wr(4'hF, 32'h00000077);
    FIFO_re = 1'b0;
    check("emptypp_udf", 32'(underflow), 32'd1);
    check("emptypp_size", 32'(FIFO_size), 32'd1);
    check("emptypp_value", FIFO_value, 32'h77);
    pop();

    // Clear with size 5 and a concurrent write
    for (int i = 0; i < 5; i++) wr(4'hF, 32'h100 + 32'(i));
    check("pre_clr_size", 32'(FIFO_size), 32'd5);
    FIFO_clr = 1'b1;
    wr(4'hF, 32'hDEADBEEF);
    FIFO_clr = 1'b0;
    check("clr_size", 32'(FIFO_size), 32'd0);
    check("clr_value", FIFO_value, 32'h0);
    check("clr_pulses", {30'h0, overflow, underflow}, 32'h0);

    // Async reset mid-stream with half-filled staging
    for (int i = 0; i < 3; i++) wr(4'hF, 32'h200 + 32'(i));
    wr(4'h3, 32'h00001234);
    check("mid_size", 32'(FIFO_size), 32'd3);
    reset_n = 1'b0;
    #2;
    check("arst_size", 32'(FIFO_size), 32'd0);
    check("arst_value", FIFO_value, 32'h0);
    check("arst_flags", {29'h0, full, overflow, underflow}, 32'h0);
    reset_n = 1'b1;
    cyc();
    wr(4'hC, 32'hCAFE5678);
    check("post_rst_size", 32'(FIFO_size), 32'd1);
    check("post_rst_value", FIFO_value, 32'hCAFE0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
